// File: rtl/lif_neuron_if.sv
// Bus between a group of synapses (master) and the lif_neuron (slave).
//   en            global enable, en=0 freezes the neuron
//   spking_value  packed signed synapse values, synapse i at [i*DW +: DW]
//   post_en       per-synapse valid
//   threshold     signed firing threshold
//   membrane      registered signed membrane potential
//   post_spiking  one-cycle output spike
//   update_en     one-cycle learning request, coincident with post_spiking
//   spike_count   spikes since reset, saturating at 255
interface lif_neuron_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned N_IN = 4
);
  logic                   en;
  logic [N_IN*DW-1:0]     spking_value;
  logic [N_IN-1:0]        post_en;
  logic signed [DW-1:0]   threshold;
  logic signed [DW-1:0]   membrane;
  logic                   post_spiking;
  logic                   update_en;
  logic [7:0]             spike_count;

  modport master (
    output en, spking_value, post_en, threshold,
    input  membrane, post_spiking, update_en, spike_count
  );

  modport slave (
    input  en, spking_value, post_en, threshold,
    output membrane, post_spiking, update_en, spike_count
  );
endinterface

// File: rtl/lif_neuron.sv
// Post-synaptic leaky integrate-and-fire neuron.
// Sums the valid synapse values, subtracts a shift-based leak, saturates, and fires when the
// potential reaches the threshold. A fire clears the membrane, pulses post_spiking/update_en
// and (for REF_CYC > 0) enters a refractory period that ignores inputs.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   bus_io  lif_neuron_if slave modport (inputs, threshold, membrane and spike outputs)
module lif_neuron #(
  parameter int unsigned DW      = 16,
  parameter int unsigned N_IN    = 4,
  parameter int unsigned LEAK_SH = 4,
  parameter int unsigned REF_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  lif_neuron_if.slave       bus_io
);

  localparam int unsigned SumW = DW + $clog2(N_IN) + 1;
  // One extra bit covers membrane - leak + sum without wrap.
  localparam int unsigned VW   = SumW + 1;
  localparam int unsigned RW   = (REF_CYC > 1) ? $clog2(REF_CYC + 1) : 1;

  localparam logic signed [DW-1:0] MaxV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MinV = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StIntegrate  = 2'b01,
    StRefractory = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] mem_q, mem_d;
  logic                 spike_q, spike_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [RW-1:0]        ref_q, ref_d;

  logic signed [SumW-1:0] sum;
  logic signed [VW-1:0]   v_full;
  logic signed [DW-1:0]   v_sat;
  logic signed [DW-1:0]   thr;

  assign thr = $signed(bus_io.threshold);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (bus_io.post_en[i]) begin
        sum = sum + SumW'($signed(bus_io.spking_value[i*DW +: DW]));
      end
    end
  end

  // Arithmetic shift rounds toward -inf, so the leak of a negative potential is negative.
  always_comb begin
    v_full = VW'(mem_q) - VW'(mem_q >>> LEAK_SH) + VW'(sum);
    if (v_full > VW'(MaxV)) begin
      v_sat = MaxV;
    end else if (v_full < VW'(MinV)) begin
      v_sat = MinV;
    end else begin
      v_sat = v_full[DW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    if (bus_io.en) begin
      unique case (state_q)
        StIdle: begin
          state_d = StIntegrate;
        end
        StIntegrate: begin
          if (v_sat >= thr) begin
            mem_d   = '0;
            spike_d = 1'b1;
            if (cnt_q != 8'hFF) begin
              cnt_d = cnt_q + 8'd1;
            end
            if (REF_CYC > 0) begin
              ref_d   = RW'(REF_CYC);
              state_d = StRefractory;
            end
          end else begin
            mem_d = v_sat;
          end
        end
        StRefractory: begin
          mem_d = '0;
          if (ref_q <= RW'(1)) begin
            ref_d   = '0;
            state_d = StIntegrate;
          end else begin
            ref_d = ref_q - RW'(1);
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mem_q   <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
    end
  end

  assign bus_io.membrane     = mem_q;
  assign bus_io.post_spiking = spike_q;
  assign bus_io.update_en    = spike_q;
  assign bus_io.spike_count  = cnt_q;

endmodule

// File: tb/tb_lif_neuron.sv
module tb_lif_neuron;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lif_neuron_if #(.DW(16), .N_IN(4)) bus ();

  lif_neuron #(
    .DW(16), .N_IN(4), .LEAK_SH(4), .REF_CYC(3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  pe;
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] thr;
    logic [15:0] em;
    logic        es;
    logic [7:0]  ec;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[24];

  function automatic vec_t mk(logic r, logic e, logic [3:0] pe, int s0, int s1, int s2, int s3,
                              int thr, int em, logic es, int ec);
    vec_t v;
    v.rst = r; v.en = e; v.pe = pe;
    v.s0 = 16'(s0); v.s1 = 16'(s1); v.s2 = 16'(s2); v.s3 = 16'(s3);
    v.thr = 16'(thr); v.em = 16'(em); v.es = es; v.ec = 8'(ec);
    return v;
  endfunction

  task automatic drive(logic r, logic e, logic [3:0] pe, int s0, int s1, int s2, int s3,
                       int thr);
    rst = r;
    bus.en = e;
    bus.post_en = pe;
    bus.spking_value = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    bus.threshold = 16'(thr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_out(string tag, int em, logic es, int ec);
    check({tag, " membrane"}, 32'(bus.membrane), 32'(16'(em)));
    check({tag, " post_spiking"}, 32'(bus.post_spiking), 32'(es));
    check({tag, " update_en"}, 32'(bus.update_en), 32'(es));
    check({tag, " spike_count"}, 32'(bus.spike_count), 32'(8'(ec)));
  endtask

  initial begin
    // Integrate/leak: 100, 100-6+100=194, 194-12+100=282
    vecs[0]  = mk(1, 0, 4'b0000,      0,      0,      0,      0,  1000,      0, 0, 0);
    vecs[1]  = mk(0, 1, 4'b0001,    100,      0,      0,      0,  1000,      0, 0, 0);
    vecs[2]  = mk(0, 1, 4'b0001,    100,      0,      0,      0,  1000,    100, 0, 0);
    vecs[3]  = mk(0, 1, 4'b0001,    100,      0,      0,      0,  1000,    194, 0, 0);
    vecs[4]  = mk(0, 1, 4'b0001,    100,      0,      0,      0,  1000,    282, 0, 0);
    // Masking: synapses 0 and 2 only
    vecs[5]  = mk(1, 1, 4'b0000,      0,      0,      0,      0,  1000,      0, 0, 0);
    vecs[6]  = mk(0, 1, 4'b0101,     10,     20,     30,     40,  1000,      0, 0, 0);
    vecs[7]  = mk(0, 1, 4'b0101,     10,     20,     30,     40,  1000,     40, 0, 0);
    // Negative saturation, leak of negative value, positive saturation equal to threshold
    vecs[8]  = mk(1, 1, 4'b0000,      0,      0,      0,      0, 32767,      0, 0, 0);
    vecs[9]  = mk(0, 1, 4'b1111, -32768, -32768, -32768, -32768, 32767,      0, 0, 0);
    vecs[10] = mk(0, 1, 4'b1111, -32768, -32768, -32768, -32768, 32767, -32768, 0, 0);
    vecs[11] = mk(0, 1, 4'b0000,      0,      0,      0,      0, 32767, -30720, 0, 0);
    vecs[12] = mk(0, 1, 4'b1111,  32767,  32767,  32767,  32767, 32767,      0, 1, 1);
    // Fire + refractory: 3 ignored cycles, then fires again
    vecs[13] = mk(1, 1, 4'b0000,      0,      0,      0,      0,   150,      0, 0, 0);
    vecs[14] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 0, 0);
    vecs[15] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 1, 1);
    vecs[16] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 0, 1);
    vecs[17] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 0, 1);
    vecs[18] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 0, 1);
    vecs[19] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 1, 2);
    vecs[20] = mk(0, 1, 4'b0001,    200,      0,      0,      0,   150,      0, 0, 2);
    // Zero threshold with zero potential fires
    vecs[21] = mk(1, 1, 4'b0000,      0,      0,      0,      0,     0,      0, 0, 0);
    vecs[22] = mk(0, 1, 4'b0000,      0,      0,      0,      0,     0,      0, 0, 0);
    vecs[23] = mk(0, 1, 4'b0000,      0,      0,      0,      0,     0,      0, 1, 1);

    drive(1, 0, 4'b0000, 0, 0, 0, 0, 1000);
    tick();

    for (int i = 0; i < 24; i++) begin
      rst = vecs[i].rst;
      bus.en = vecs[i].en;
      bus.post_en = vecs[i].pe;
      bus.spking_value = {vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0};
      bus.threshold = vecs[i].thr;
      tick();
      check_out($sformatf("vec%0d", i), int'($signed(vecs[i].em)), vecs[i].es, int'(vecs[i].ec));
    end

    // Enable gating: build 194, freeze 5 cycles with a threshold that would fire, then fire
    drive(1, 1, 4'b0000, 0, 0, 0, 0, 1000);
    tick();
    drive(0, 1, 4'b0001, 100, 0, 0, 0, 1000);
    tick();
    tick();
    tick();
    check_out("gate_pre", 194, 0, 0);
    drive(0, 0, 4'b1111, 100, 100, 100, 100, 150);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("gate%0d", i), 194, 0, 0);
    end
    drive(0, 1, 4'b0001, 100, 0, 0, 0, 150);
    tick();
    check_out("gate_fire", 0, 1, 1);

    // Reset at the 2nd refractory cycle
    tick();
    check_out("ref1", 0, 0, 1);
    drive(1, 1, 4'b0001, 50, 0, 0, 0, 1000);
    tick();
    check_out("ref_rst", 0, 0, 0);
    drive(0, 1, 4'b0001, 50, 0, 0, 0, 1000);
    tick();
    check_out("post_rst_idle", 0, 0, 0);
    tick();
    check_out("post_rst_int", 50, 0, 0);

    // Spike counter saturation: most negative threshold fires every integrate cycle
    drive(1, 1, 4'b0000, 0, 0, 0, 0, -32768);
    tick();
    drive(0, 1, 4'b0000, 0, 0, 0, 0, -32768);
    for (int i = 0; i < 1100; i++) tick();
    check("cnt_sat", 32'(bus.spike_count), 32'd255);
    for (int i = 0; i < 8; i++) tick();
    check("cnt_hold", 32'(bus.spike_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
